// File: rtl/fetch_decode.sv
// fetch_decode: front-end stage that fetches 32-bit instructions, holds the
// current one in IR, decodes it for the DEC/ALU/WR datapath and stalls on
// read-after-write hazards against the write-back shadow pipeline.
//
// Ports:
//   clk, reset              sole clock (rising edge), async active-high reset
//   imem_req/imem_addr      fetch request and address (address = pc)
//   imem_rdata/imem_valid   instruction return, accepted only while fetching
//   addr_a/addr_b           DEC-stage register read addresses (IR.ra / IR.rb)
//   imm, f                  sign-extended immediate and operand select (1 = imm)
//   f_alu                   f delayed one cycle for the ALU stage
//   addr_d/wr_regfile       write-back destination and enable
//   pc                      current fetch pc
//   halted                  HALT retired
//   illegal                 sticky flag, an unknown opcode was executed
module fetch_decode #(
    parameter int                LENGTH   = 32,
    parameter int                NREGS    = 32,
    parameter int                SEL_BITS = $clog2(NREGS),
    parameter logic [LENGTH-1:0] RESET_PC = {LENGTH{1'b0}}
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [LENGTH-1:0]   imem_addr,
    input  logic [LENGTH-1:0]   imem_rdata,
    input  logic                imem_valid,
    output logic [SEL_BITS-1:0] addr_a,
    output logic [SEL_BITS-1:0] addr_b,
    output logic [LENGTH-1:0]   imm,
    output logic                f,
    output logic                f_alu,
    output logic [SEL_BITS-1:0] addr_d,
    output logic                wr_regfile,
    output logic [LENGTH-1:0]   pc,
    output logic                halted,
    output logic                illegal
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_HALT   = 2'd2
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h01;
    localparam logic [5:0] OP_HALT = 6'h3E;
    localparam logic [5:0] OP_NOP  = 6'h3F;

    localparam logic [LENGTH-1:0] NOP_WORD = LENGTH'(32'hFC00_0000);
    localparam logic [LENGTH-1:0] PC_STEP  = LENGTH'(32'd4);

    state_t              state_q, state_d;
    logic [LENGTH-1:0]   ir_q, ir_d;
    logic [LENGTH-1:0]   pc_q, pc_d;
    logic                v_alu_q, v_alu_d;
    logic                v_wr_q, v_wr_d;
    logic [SEL_BITS-1:0] rd_alu_q, rd_alu_d;
    logic [SEL_BITS-1:0] rd_wr_q, rd_wr_d;
    logic                f_alu_q, f_alu_d;
    logic                illegal_q, illegal_d;

    logic [5:0]          op_s;
    logic [SEL_BITS-1:0] rd_s, ra_s, rb_s;
    logic [LENGTH-1:0]   imm_s;
    logic                is_add_s, is_addi_s, is_halt_s, is_illegal_s;
    logic                ra_busy_s, rb_busy_s, hazard_s;
    logic                issue_s;

    // Decode of the instruction register and RAW hazard detection.
    always_comb begin
        op_s         = ir_q[31:26];
        rd_s         = ir_q[21 +: SEL_BITS];
        ra_s         = ir_q[16 +: SEL_BITS];
        rb_s         = ir_q[11 +: SEL_BITS];
        imm_s        = {{(LENGTH-16){ir_q[15]}}, ir_q[15:0]};
        is_add_s     = 1'b0;
        is_addi_s    = 1'b0;
        is_halt_s    = 1'b0;
        is_illegal_s = 1'b0;
        case (op_s)
            OP_ADD:  is_add_s     = 1'b1;
            OP_ADDI: is_addi_s    = 1'b1;
            OP_HALT: is_halt_s    = 1'b1;
            OP_NOP:  is_illegal_s = 1'b0;
            default: is_illegal_s = 1'b1;
        endcase
        // A source is busy while its producer sits in the ALU or WR slot;
        // register 0 gets no special treatment.
        ra_busy_s = (v_alu_q && (rd_alu_q == ra_s)) || (v_wr_q && (rd_wr_q == ra_s));
        rb_busy_s = (v_alu_q && (rd_alu_q == rb_s)) || (v_wr_q && (rd_wr_q == rb_s));
        hazard_s  = ((is_add_s || is_addi_s) && ra_busy_s) || (is_add_s && rb_busy_s);
    end

    // Next-state logic for the fetch/decode FSM, pc, IR and shadow pipeline.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        illegal_d = illegal_q;
        issue_s   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (hazard_s) begin
                    state_d = S_DECODE;
                end else if (is_halt_s) begin
                    state_d = S_HALT;
                end else begin
                    issue_s   = 1'b1;
                    pc_d      = pc_q + PC_STEP;
                    state_d   = S_FETCH;
                    illegal_d = illegal_q | is_illegal_s;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        // Shadow pipeline advances every cycle so writes drain even when halted.
        v_alu_d  = issue_s && (is_add_s || is_addi_s);
        rd_alu_d = rd_s;
        v_wr_d   = v_alu_q;
        rd_wr_d  = rd_alu_q;
        f_alu_d  = is_addi_s;
    end

    // State and datapath-control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ir_q      <= NOP_WORD;
            pc_q      <= RESET_PC;
            v_alu_q   <= 1'b0;
            v_wr_q    <= 1'b0;
            rd_alu_q  <= {SEL_BITS{1'b0}};
            rd_wr_q   <= {SEL_BITS{1'b0}};
            f_alu_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            v_alu_q   <= v_alu_d;
            v_wr_q    <= v_wr_d;
            rd_alu_q  <= rd_alu_d;
            rd_wr_q   <= rd_wr_d;
            f_alu_q   <= f_alu_d;
            illegal_q <= illegal_d;
        end
    end

    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign addr_a     = ra_s;
    assign addr_b     = rb_s;
    assign imm        = imm_s;
    assign f          = is_addi_s;
    assign f_alu      = f_alu_q;
    assign addr_d     = rd_wr_q;
    assign wr_regfile = v_wr_q;
    assign halted     = (state_q == S_HALT);
    assign illegal    = illegal_q;

endmodule
